multicycle_cpu_core: RTL
========================

// Module: multicycle_cpu_core
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle 16-bit core; same 16-bit instruction format.
//  FSM sequences FETCH/DECODE/EXEC/MEM/WB, so instruction and data memory may insert wait states.
//  Memories use req/ready handshakes. Sits between the instruction ROM and the data RAM at top level.
// PARAMETERS
//  DATA_W    16  register/ALU/data width, >=16
//  ADDR_W    16  PC and memory word-address width, >=12
//  RESET_PC  0   PC value loaded at reset
//  LINK_REG  15  register written by JAL, 1..15
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-low
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  ADDR_W  fetch word address (= pc)
//  imem_ready   in   1       fetch done; imem_rdata valid this cycle
//  imem_rdata   in   16      instruction word
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1 = store, 0 = load; valid with dmem_req
//  dmem_addr    out  ADDR_W  data word address
//  dmem_wdata   out  DATA_W  store data
//  dmem_ready   in   1       access done; dmem_rdata valid this cycle for loads
//  dmem_rdata   in   DATA_W  load data
//  pc_out       out  ADDR_W  current PC
//  retire       out  1       1-cycle pulse, one per completed instruction
//  halted       out  1       core stopped by HALT
// BEHAVIOUR
//  Reset (rst=0 at edge): pc=RESET_PC, all 16 regs=0, IR=0, state=IDLE.
//  - All req/we/retire/halted outputs are 0 in IDLE. An outstanding request is abandoned; a late ready is ignored.
//  Fields: op=ir[15:12], rs=ir[11:8], rt=ir[7:4], rd=ir[3:0].
//  - imm4 = sext(ir[3:0]); imm8 = sext(ir[7:0]); imm12 = zext(ir[11:0]).
//  - R0 always reads 0; writes to R0 are discarded.
//  Ops:
//  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs op rt.
//  - 5 SLT: rd = (signed rs < rt) ? 1 : 0.
//  - 6 ADDI: rt = rs + imm4.   7 LW: rt = mem[rs+imm4].   8 SW: mem[rs+imm4] = rt.
//  - 9 BEQ: if rs==rt, pc = pc+1+imm4.
//  - A J: pc = imm12.   B JAL: R[LINK_REG] = pc+1, then pc = imm12.   C JR: pc = rs[ADDR_W-1:0].
//  - D LI: R[rs] = imm8.   E MOV: rd = rs.   F HALT.
//  States:
//  - IDLE -> FETCH, unconditionally.
//  - FETCH: imem_req=1, imem_addr=pc. Stays until imem_ready=1 at an edge; then IR=imem_rdata -> DECODE.
//  - DECODE: read rs/rt into operand regs -> EXEC, or HALT if op=F.
//  - EXEC: ALU result latched.
//    - LW/SW -> MEM.
//    - J/JAL/JR/BEQ: pc updated here, retire=1; JAL -> WB, others -> FETCH.
//    - All other ops -> WB with pc=pc+1.
//  - MEM: dmem_req=1; dmem_addr=alu[ADDR_W-1:0]; dmem_we=(op==SW); dmem_wdata=rt. Held stable until dmem_ready.
//    - LW: latch rdata -> WB.   SW: pc=pc+1, retire=1 -> FETCH.
//  - WB: write destination, retire=1 (except JAL, already retired in EXEC) -> FETCH.
//  - HALT: halted=1, no requests; left only by reset.
//  Handshake:
//  - ready may arrive in the same cycle as req (zero wait). Every wait cycle adds exactly one cycle.
//  - req drops the cycle after a completed transfer. ready while req=0 is ignored.
//  Latency at zero wait (FETCH to next FETCH):
//  - ALU/ADDI/LI/MOV: 4. LW: 5. SW: 4. J/JR/BEQ: 3. JAL: 4.
//  Arithmetic: mod 2^DATA_W, no flags. pc wraps 2^ADDR_W-1 -> 0. Immediates extend to DATA_W/ADDR_W as listed.
// TESTING
//  1. Release reset. Required: imem_req rises on the 2nd edge after release with imem_addr=RESET_PC.
//     Feed LI R1,0x7F; LI R2,0x80 (zero wait). Required: R1=0x007F, R2=0xFF80; retire pulses 4 cycles apart.
//  2. R1=5, R2=3. Run ADD R3,R1,R2; SUB R4,R2,R1; SLT R5,R4,R1.
//     Required: R3=8, R4=0xFFFE, R5=1. ADD R0,R1,R2 leaves R0 reading 0.
//  3. SW R1,R2,+2 with R2=0x10, R1=0xBEEF; dmem_ready delayed 3 cycles.
//     Required: req/we held with addr=0x12, wdata=0xBEEF. LW R6,R2,+2 returns 0xBEEF after 5+3 cycles.
//  4. At pc=0x20: BEQ R1,R1,-2 -> pc=0x1F. JAL 0x100 -> R15=pc+1, pc=0x100. JR R15 returns.
//     J 0xFFF on ADDR_W=16 -> pc=0x0FFF.
//  5. Assert rst while imem_req waits with no ready. Required: req=0 after that edge; a later ready is ignored.
//     Fetch restarts at RESET_PC; registers read 0.
//  6. HALT. Required: halted=1 from the edge after DECODE; no further req for 20 cycles; reset clears halted.

Source files
------------

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle core for the 16-bit instruction set: IDLE/FETCH/DECODE/EXEC/MEM/WB
// sequencer with req/ready handshakes towards instruction and data memory.
module multicycle_cpu_core #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int LINK_REG = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3, OP_XOR = 4'h4, OP_SLT = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6, OP_LW  = 4'h7, OP_SW  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9, OP_J   = 4'hA, OP_JAL = 4'hB;
    localparam logic [3:0] OP_JR   = 4'hC, OP_LI  = 4'hD, OP_MOV = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t state, state_nx;
    logic [ADDR_W-1:0] pc, pc_inc, pc_br, pc_exec, imm12;
    logic [15:0] ir;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] opa, opb, alu, mdr, alu_nx, wb_data, imm4, imm8;
    logic [3:0] op, rs, rt, rd, wb_reg;
    logic wb_en, is_flow;

    assign op = ir[15:12];
    assign rs = ir[11:8];
    assign rt = ir[7:4];
    assign rd = ir[3:0];

    assign imm4   = DATA_W'($signed(ir[3:0]));
    assign imm8   = DATA_W'($signed(ir[7:0]));
    assign imm12  = ADDR_W'(ir[11:0]);
    assign pc_inc = pc + ADDR_W'(1);
    assign pc_br  = pc_inc + ADDR_W'($signed(ir[3:0]));

    assign is_flow = (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
    assign wb_data = (op == OP_LW) ? mdr : alu;

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = ADDR_W'(alu);
    assign dmem_wdata = opb;

    always_comb begin
        alu_nx = '0;
        case (op)
            OP_ADD:               alu_nx = opa + opb;
            OP_SUB:               alu_nx = opa - opb;
            OP_AND:               alu_nx = opa & opb;
            OP_OR:                alu_nx = opa | opb;
            OP_XOR:               alu_nx = opa ^ opb;
            OP_SLT:               alu_nx = DATA_W'($signed(opa) < $signed(opb));
            OP_ADDI, OP_LW, OP_SW: alu_nx = opa + imm4;
            OP_JAL:               alu_nx = DATA_W'(pc_inc);
            OP_LI:                alu_nx = imm8;
            OP_MOV:               alu_nx = opa;
            default:              alu_nx = '0;
        endcase
    end

    // Memory ops advance the pc only once the data transfer completes.
    always_comb begin
        pc_exec = pc_inc;
        case (op)
            OP_LW, OP_SW: pc_exec = pc;
            OP_BEQ:       pc_exec = (opa == opb) ? pc_br : pc_inc;
            OP_J, OP_JAL: pc_exec = imm12;
            OP_JR:        pc_exec = ADDR_W'(opa);
            default:      pc_exec = pc_inc;
        endcase
    end

    always_comb begin
        wb_en  = 1'b1;
        wb_reg = rd;
        case (op)
            OP_ADDI, OP_LW: wb_reg = rt;
            OP_LI:          wb_reg = rs;
            OP_JAL:         wb_reg = 4'(LINK_REG);
            OP_SW, OP_BEQ, OP_J, OP_JR, OP_HALT: wb_en = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_nx = S_MEM;
                end else if (is_flow) begin
                    retire   = 1'b1;
                    state_nx = (op == OP_JAL) ? S_WB : S_FETCH;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (dmem_ready) begin
                    retire   = (op == OP_SW);
                    state_nx = (op == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire   = (op != OP_JAL);
                state_nx = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= ADDR_W'(RESET_PC);
            ir    <= '0;
            opa   <= '0;
            opb   <= '0;
            alu   <= '0;
            mdr   <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: if (imem_ready) ir <= imem_rdata;
                S_DECODE: begin
                    opa <= regs[rs];
                    opb <= regs[rt];
                end
                S_EXEC: begin
                    alu <= alu_nx;
                    pc  <= pc_exec;
                end
                S_MEM: if (dmem_ready) begin
                    mdr <= dmem_rdata;
                    pc  <= pc_inc;
                end
                S_WB: if (wb_en && wb_reg != 4'd0) regs[wb_reg] <= wb_data;
                default: ;
            endcase
        end
    end
endmodule
